// File: rtl/pipe_lsu.sv
// Load/store unit: one outstanding single-beat data-memory access, with lane-aligned,
// sign- or zero-extended results. Defining LSU_MISALIGN_CHECK_EN enables misaligned-access trapping.
module pipe_lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_store_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  output logic            mem_req_we_o,
  output logic [3:0]      mem_req_wstrb_o,
  output logic [XLEN-1:0] mem_req_wdata_o,
  input  logic            mem_rsp_valid_i,
  input  logic [XLEN-1:0] mem_rsp_rdata_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_data_o,
  output logic            res_misalign_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              store_q, store_d;
  logic [1:0]        off_q, off_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [3:0]        strb_q, strb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   res_q, res_d;
`ifdef LSU_MISALIGN_CHECK_EN
  logic              mis_q, mis_d;
  logic              mis_req;
`endif

  logic [3:0]        strb_n;
  logic [XLEN-1:0]   wdata_n;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   ld;

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    uns_d   = uns_q;
    store_d = store_q;
    off_d   = off_q;
    addr_d  = addr_q;
    strb_d  = strb_q;
    wdata_d = wdata_q;
    res_d   = res_q;
`ifdef LSU_MISALIGN_CHECK_EN
    mis_d   = mis_q;
    mis_req = ((req_size_i == 2'd1) && req_addr_i[0]) ||
              (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`endif

    // Strobe shift stays in 4 bits, so misaligned halves simply lose their upper lane.
    case (req_size_i)
      2'd0:    strb_n = 4'b0001 << req_addr_i[1:0];
      2'd1:    strb_n = 4'b0011 << req_addr_i[1:0];
      default: strb_n = 4'b1111;
    endcase

    case (req_size_i)
      2'd0:    wdata_n = {4{req_wdata_i[7:0]}};
      2'd1:    wdata_n = {2{req_wdata_i[15:0]}};
      default: wdata_n = req_wdata_i;
    endcase

    sh = mem_rsp_rdata_i >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ld = uns_q ? {{(XLEN-8){1'b0}}, sh[7:0]}
                          : {{(XLEN-8){sh[7]}}, sh[7:0]};
      2'd1:    ld = uns_q ? {{(XLEN-16){1'b0}}, sh[15:0]}
                          : {{(XLEN-16){sh[15]}}, sh[15:0]};
      default: ld = sh;
    endcase

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          store_d = req_store_i;
          off_d   = req_addr_i[1:0];
          addr_d  = {req_addr_i[XLEN-1:2], 2'b00};
          strb_d  = strb_n;
          wdata_d = wdata_n;
          res_d   = '0;
          state_d = S_REQ;
`ifdef LSU_MISALIGN_CHECK_EN
          mis_d   = 1'b0;
          if (mis_req) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_REQ: begin
        if (mem_req_ready_i) state_d = S_RSP;
      end
      S_RSP: begin
        if (mem_rsp_valid_i) begin
          res_d   = store_q ? '0 : ld;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      off_q   <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      store_q <= store_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
`ifdef LSU_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Outputs are forced low combinationally while reset is held, not just after the edge.
  assign req_ready_o     = (state_q == S_IDLE) && !rst_i;
  assign mem_req_valid_o = (state_q == S_REQ) && !rst_i;
  assign mem_req_we_o    = (state_q == S_REQ) && store_q && !rst_i;
  assign mem_req_addr_o  = rst_i ? '0 : addr_q;
  assign mem_req_wstrb_o = rst_i ? '0 : strb_q;
  assign mem_req_wdata_o = rst_i ? '0 : wdata_q;
  assign res_valid_o     = (state_q == S_DONE) && !rst_i;
  assign res_data_o      = rst_i ? '0 : res_q;
`ifdef LSU_MISALIGN_CHECK_EN
  assign res_misalign_o  = mis_q && !rst_i;
`else
  assign res_misalign_o  = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_lsu.sv
// Self-checking bench for pipe_lsu: table-driven accesses with a result scoreboard,
// plus backpressure, misaligned-word and mid-access reset sequences.
module tb_pipe_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic        mreq_valid, mreq_ready, mreq_we;
  logic [31:0] mreq_addr, mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mrsp_valid;
  logic [31:0] mrsp_rdata;
  logic        res_valid, res_ready, res_mis;
  logic [31:0] res_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  pipe_lsu #(.XLEN(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_store_i    (req_store),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .mem_req_valid_o(mreq_valid),
    .mem_req_ready_i(mreq_ready),
    .mem_req_addr_o (mreq_addr),
    .mem_req_we_o   (mreq_we),
    .mem_req_wstrb_o(mreq_wstrb),
    .mem_req_wdata_o(mreq_wdata),
    .mem_rsp_valid_i(mrsp_valid),
    .mem_rsp_rdata_i(mrsp_rdata),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .res_misalign_o (res_mis)
  );

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [3:0]  strb;
    logic [31:0] mwdata;
    logic [31:0] res;
    logic        mis;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input vec_t v, input int unsigned req_stall, input int unsigned res_stall);
    exp_t        e, got;
    int unsigned lat;
    check("idle_ready", {31'b0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_store    = v.st;
    req_size     = v.sz;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    e.res = v.res;
    e.mis = v.mis;
    sb_q.push_back(e);
    tick();
    lat = 1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    if (v.mis) begin
      check("mis_no_bus", {31'b0, mreq_valid}, 32'd0);
    end else begin
      check("early_res_valid", {31'b0, res_valid}, 32'd0);
      check("req_ready_busy", {31'b0, req_ready}, 32'd0);
      check("mreq_valid", {31'b0, mreq_valid}, 32'd1);
      check("mreq_addr", mreq_addr, v.maddr);
      check("mreq_we", {31'b0, mreq_we}, {31'b0, v.st});
      check("mreq_wstrb", {28'b0, mreq_wstrb}, {28'b0, v.strb});
      check("mreq_wdata", mreq_wdata, v.mwdata);
      for (int unsigned i = 0; i < req_stall; i++) begin
        mreq_ready = 1'b0;
        mrsp_valid = 1'b1;
        tick();
        lat++;
        check("stall_valid", {31'b0, mreq_valid}, 32'd1);
        check("stall_addr", mreq_addr, v.maddr);
        check("stall_wstrb", {28'b0, mreq_wstrb}, {28'b0, v.strb});
        check("stall_wdata", mreq_wdata, v.mwdata);
      end
      mrsp_valid = 1'b0;
      mreq_ready = 1'b1;
      tick();
      lat++;
      mreq_ready = 1'b0;
      check("rsp_no_valid", {31'b0, mreq_valid}, 32'd0);
      check("rsp_we_low", {31'b0, mreq_we}, 32'd0);
      mrsp_valid = 1'b1;
      mrsp_rdata = v.rdata;
      tick();
      lat++;
      mrsp_valid = 1'b0;
      mrsp_rdata = $urandom;
    end
    check("res_valid", {31'b0, res_valid}, 32'd1);
    check("latency", lat, v.mis ? 32'd1 : 32'd3 + req_stall);
    for (int unsigned i = 0; i < res_stall; i++) begin
      res_ready = 1'b0;
      tick();
      lat++;
      check("hold_valid", {31'b0, res_valid}, 32'd1);
      check("hold_data", res_data, v.res);
      check("hold_busy", {31'b0, req_ready}, 32'd0);
    end
    res_ready = 1'b1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      got = sb_q.pop_front();
      check("res_data", res_data, got.res);
      check("res_mis", {31'b0, res_mis}, {31'b0, got.mis});
    end
    check("hs_cycle", lat, (v.mis ? 32'd1 : 32'd3 + req_stall) + res_stall);
    tick();
    res_ready = 1'b0;
    check("release_ready", {31'b0, req_ready}, 32'd1);
    check("release_valid", {31'b0, res_valid}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd0);
    check({tag, "_mvalid"}, {31'b0, mreq_valid}, 32'd0);
    check({tag, "_we"}, {31'b0, mreq_we}, 32'd0);
    check({tag, "_maddr"}, mreq_addr, 32'd0);
    check({tag, "_wstrb"}, {28'b0, mreq_wstrb}, 32'd0);
    check({tag, "_mwdata"}, mreq_wdata, 32'd0);
    check({tag, "_rvalid"}, {31'b0, res_valid}, 32'd0);
    check({tag, "_rdata"}, res_data, 32'd0);
    check({tag, "_mis"}, {31'b0, res_mis}, 32'd0);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h0, 32'h80AB_CDEF, 32'h8000_0000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 1'b1, 32'h8000_0002, 32'h0, 32'h9234_5678, 32'h8000_0000, 4'b1100, 32'h0, 32'h0000_9234, 1'b0};
    tbl[2]  = '{1'b0, 2'd1, 1'b0, 32'h8000_0002, 32'h0, 32'h9234_5678, 32'h8000_0000, 4'b1100, 32'h0, 32'hFFFF_9234, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h8000_0001, 32'h1234_56A5, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 32'h8000_0004, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hCAFE_F00D, 32'h1111_1111, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0, 1'b0};
    tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h0000_0082, 32'h0000_BEEF, 32'h2222_2222, 32'h0000_0080, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0, 32'h0000_F100, 32'h0000_0000, 4'b0010, 32'h0, 32'h0000_00F1, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h0, 32'h007F_0000, 32'h0000_0000, 4'b0100, 32'h0, 32'h0000_007F, 1'b0};
    tbl[9]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0008, 32'h0, 32'h1122_3344, 32'h0000_0008, 4'b1111, 32'h0, 32'h1122_3344, 1'b0};
    tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_0000, 32'h0, 32'h0001_8000, 32'h0000_0000, 4'b0011, 32'h0, 32'hFFFF_8000, 1'b0};

    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    mreq_ready = 1'b0; mrsp_valid = 1'b0; mrsp_rdata = '0; res_ready = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    #1;
    check("post_reset_ready", {31'b0, req_ready}, 32'd1);

    foreach (tbl[i]) do_op(tbl[i], 0, 0);

    v = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'h55AA_55AA, 32'h0000_0100, 4'b1111, 32'h0, 32'h55AA_55AA, 1'b0};
    do_op(v, 3, 2);

`ifdef LSU_MISALIGN_CHECK_EN
    v = '{1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 32'h9234_5678, 32'h8000_0000, 4'b1111, 32'h0, 32'h0, 1'b1};
`else
    v = '{1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 32'h9234_5678, 32'h8000_0000, 4'b1111, 32'h0, 32'h0000_9234, 1'b0};
`endif
    do_op(v, 0, 0);

    // Abandon an access in RSP, then check a stale response does not leak through.
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0200;
    tick();
    req_valid = 1'b0;
    mreq_ready = 1'b1;
    tick();
    mreq_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("rst_hold");
    tick();
    check_all_zero("rst_edge");
    rst = 1'b0;
    mrsp_valid = 1'b1;
    mrsp_rdata = 32'hBAD0_BAD0;
    tick();
    mrsp_valid = 1'b0;
    check("late_rsp_ready", {31'b0, req_ready}, 32'd1);
    check("late_rsp_rvalid", {31'b0, res_valid}, 32'd0);
    check("late_rsp_mvalid", {31'b0, mreq_valid}, 32'd0);

    v = '{1'b0, 2'd2, 1'b0, 32'h0000_0204, 32'h0, 32'h0BAD_F00D, 32'h0000_0204, 4'b1111, 32'h0, 32'h0BAD_F00D, 1'b0};
    do_op(v, 1, 1);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
